usr_shift_reg: RTL and testbench

Parametrised universal shift register: the next generation of the team's 4-bit load/shift/hold register with tri-state output. Adds configurable width, serial inputs and outputs, rotate and arithmetic modes, and a counted burst-shift engine with BUSY/DONE handshake. It sits between parallel data sources and serial/bit-manipulation consumers on a single clock domain.

---
 rtl/usr_pkg.sv | 35 +++
 rtl/usr_burst_ctrl.sv | 72 +++++++
 rtl/usr_shift_reg.sv | 74 +++++++
 tb/tb_usr_shift_reg.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: mode codes, FSM encoding, mode classifier.
// Latency: n/a (constants and a pure function only).
// Backpressure: n/a.
// Optional feature macro: USR_ROTATE_EN enables rotate modes 100/101; without it they act as hold.
package usr_pkg;

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_SHR  = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_LOAD = 3'b011;
  localparam logic [2:0] MODE_ROR  = 3'b100;
  localparam logic [2:0] MODE_ROL  = 3'b101;
  localparam logic [2:0] MODE_ASR  = 3'b110;
  localparam logic [2:0] MODE_RSVD = 3'b111;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

  // A mode may be repeated by the burst engine only if it moves bits.
  function automatic logic is_shift_class(input logic [2:0] m);
    logic r;
    r = 1'b0;
    case (m)
      MODE_SHR, MODE_SHL, MODE_ASR: r = 1'b1;
`ifdef USR_ROTATE_EN
      MODE_ROR, MODE_ROL:           r = 1'b1;
`else
      MODE_ROR, MODE_ROL:           r = 1'b0;
`endif
      default:                      r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/usr_burst_ctrl.sv
// Burst controller: decides which mode the datapath applies each edge and runs counted bursts.
// Latency: BUSY one edge after accept; DONE pulses for the cycle after the last step.
// Backpressure: none; START outside IDLE is ignored, START in the DONE cycle is accepted.
// Ports: clk/rst_n; s/start/cnt requests in; mode (to datapath), busy, done out.
// Macro USR_ROTATE_EN (via usr_pkg::is_shift_class) decides whether rotates can burst.
module usr_burst_ctrl
  import usr_pkg::*;
#(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [2:0]    s,
  input  logic          start,
  input  logic [CW-1:0] cnt,
  output logic [2:0]    mode,
  output logic          busy,
  output logic          done
);

  logic [0:0]    state;
  logic [2:0]    mode_q;
  logic [CW-1:0] rem;
  logic          accept;

  // Any shift-class START in IDLE is consumed here, including CNT=0 requests.
  assign accept = (state == ST_IDLE) && start && is_shift_class(s);
  assign busy   = (state == ST_BURST);

  // The accepting edge itself holds the register; shifting starts on the next edge.
  always_comb begin
    mode = s;
    if (state == ST_BURST) begin
      mode = mode_q;
    end else if (accept) begin
      mode = MODE_HOLD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      mode_q <= MODE_HOLD;
      rem    <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (cnt != '0) begin
              state  <= ST_BURST;
              mode_q <= s;
              rem    <= cnt;
            end else begin
              done <= 1'b1;
            end
          end
        end
        ST_BURST: begin
          rem <= rem - CW'(1);
          if (rem == CW'(1)) begin
            state <= ST_IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/usr_shift_reg.sv
// Universal shift register: hold/shift/load/rotate/arith-shift with counted bursts and tri-state Q.
// Latency: one edge from mode sample to register update; Q/SO_R/SO_L are combinational from reg.
// Backpressure: none; BUSY flags an active burst, during which S/D/START/CNT are ignored.
// Ports: CLK, RST_N (async low); OE, S, D, SR_IN, SL_IN, START, CNT in; Q, SO_R, SO_L, BUSY, DONE out.
// Macro USR_ROTATE_EN: defined enables rotate right/left (S=100/101); undefined they hold.
module usr_shift_reg
  import usr_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             OE,
  input  logic [2:0]       S,
  input  logic [WIDTH-1:0] D,
  input  logic             SR_IN,
  input  logic             SL_IN,
  input  logic             START,
  input  logic [CW-1:0]    CNT,
  output logic [WIDTH-1:0] Q,
  output logic             SO_R,
  output logic             SO_L,
  output logic             BUSY,
  output logic             DONE
);

  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] nxt;
  logic [2:0]       mode;

  usr_burst_ctrl #(.CW(CW)) u_ctrl (
    .clk   (CLK),
    .rst_n (RST_N),
    .s     (S),
    .start (START),
    .cnt   (CNT),
    .mode  (mode),
    .busy  (BUSY),
    .done  (DONE)
  );

  // Serial inputs are sampled live on every step, including within a burst.
  always_comb begin
    nxt = r;
    case (mode)
      MODE_SHR:  nxt = {SR_IN, r[WIDTH-1:1]};
      MODE_SHL:  nxt = {r[WIDTH-2:0], SL_IN};
      MODE_LOAD: nxt = D;
`ifdef USR_ROTATE_EN
      MODE_ROR:  nxt = {r[0], r[WIDTH-1:1]};
      MODE_ROL:  nxt = {r[WIDTH-2:0], r[WIDTH-1]};
`else
      MODE_ROR, MODE_ROL: nxt = r;
`endif
      MODE_ASR:  nxt = {r[WIDTH-1], r[WIDTH-1:1]};
      default:   nxt = r;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r <= '0;
    end else begin
      r <= nxt;
    end
  end

  // OE gates only the parallel output; serial taps stay live for chaining.
  assign Q    = OE ? {WIDTH{1'bz}} : r;
  assign SO_R = r[0];
  assign SO_L = r[WIDTH-1];

endmodule

// File: tb/tb_usr_shift_reg.sv
module tb_usr_shift_reg;

  localparam int W  = 8;
  localparam int CW = 4;

  logic          CLK = 1'b0;
  logic          RST_N;
  logic          OE;
  logic [2:0]    S;
  logic [W-1:0]  D;
  logic          SR_IN;
  logic          SL_IN;
  logic          START;
  logic [CW-1:0] CNT;
  wire  [W-1:0]  Q;
  logic          SO_R;
  logic          SO_L;
  logic          BUSY;
  logic          DONE;

  int tests = 0;
  int fails = 0;

  always #5 CLK = ~CLK;

  usr_shift_reg #(.WIDTH(W)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .OE    (OE),
    .S     (S),
    .D     (D),
    .SR_IN (SR_IN),
    .SL_IN (SL_IN),
    .START (START),
    .CNT   (CNT),
    .Q     (Q),
    .SO_R  (SO_R),
    .SO_L  (SO_L),
    .BUSY  (BUSY),
    .DONE  (DONE)
  );

  // One rising edge, then settle; inputs are changed and outputs sampled here.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic load(input logic [W-1:0] v);
    S = 3'b011; D = v; START = 1'b0;
    step();
    S = 3'b000;
  endtask

  task automatic test_reset();
    RST_N = 1'b0; OE = 1'b0; S = 3'b000; D = '0; SR_IN = 1'b0; SL_IN = 1'b0;
    START = 1'b0; CNT = '0;
    step(); step();
    tests++; if (Q !== 8'h00) begin fails++; $display("FAIL reset_q: got %h want 00", Q); end
    tests++; if (BUSY !== 1'b0 || DONE !== 1'b0) begin fails++; $display("FAIL reset_flags: busy %b done %b want 0 0", BUSY, DONE); end
    tests++; if (SO_R !== 1'b0 || SO_L !== 1'b0) begin fails++; $display("FAIL reset_so: sor %b sol %b want 0 0", SO_R, SO_L); end
    RST_N = 1'b1;
    step();
  endtask

  task automatic test_load_shift();
    load(8'hA5);
    tests++; if (Q !== 8'hA5) begin fails++; $display("FAIL load_a5: got %h want a5", Q); end
    S = 3'b001; SR_IN = 1'b1;
    step();
    tests++; if (Q !== 8'hD2) begin fails++; $display("FAIL shr_d2: got %h want d2", Q); end
    S = 3'b010; SL_IN = 1'b0;
    step();
    tests++; if (Q !== 8'hA4) begin fails++; $display("FAIL shl_a4: got %h want a4", Q); end
    tests++; if (SO_R !== 1'b0 || SO_L !== 1'b1) begin fails++; $display("FAIL so_a4: sor %b sol %b want 0 1", SO_R, SO_L); end
    S = 3'b000; SR_IN = 1'b0;
    step();
    tests++; if (Q !== 8'hA4) begin fails++; $display("FAIL hold_a4: got %h want a4", Q); end
    S = 3'b111;
    step();
    tests++; if (Q !== 8'hA4) begin fails++; $display("FAIL rsvd_a4: got %h want a4", Q); end
  endtask

  task automatic test_asr();
    load(8'h81);
    S = 3'b110;
    step();
    tests++; if (Q !== 8'hC0) begin fails++; $display("FAIL asr_c0: got %h want c0", Q); end
    step();
    tests++; if (Q !== 8'hE0) begin fails++; $display("FAIL asr_e0: got %h want e0", Q); end
  endtask

  task automatic test_rotate();
    load(8'h81);
    S = 3'b100;
    step();
`ifdef USR_ROTATE_EN
    tests++; if (Q !== 8'hC0) begin fails++; $display("FAIL ror_c0: got %h want c0", Q); end
    load(8'h81);
    S = 3'b101;
    step();
    tests++; if (Q !== 8'h03) begin fails++; $display("FAIL rol_03: got %h want 03", Q); end
`else
    tests++; if (Q !== 8'h81) begin fails++; $display("FAIL ror_off_hold: got %h want 81", Q); end
    S = 3'b101;
    step();
    tests++; if (Q !== 8'h81) begin fails++; $display("FAIL rol_off_hold: got %h want 81", Q); end
    START = 1'b1; CNT = 4'd3; S = 3'b101;
    step();
    START = 1'b0; S = 3'b000;
    tests++; if (BUSY !== 1'b0 || DONE !== 1'b0) begin fails++; $display("FAIL rol_off_start: busy %b done %b want 0 0", BUSY, DONE); end
    step();
    tests++; if (DONE !== 1'b0 || Q !== 8'h81) begin fails++; $display("FAIL rol_off_after: done %b q %h want 0 81", DONE, Q); end
`endif
    S = 3'b000;
  endtask

  task automatic test_burst();
    load(8'h0F);
    S = 3'b010; SL_IN = 1'b0; START = 1'b1; CNT = 4'd4;
    step();
    tests++; if (BUSY !== 1'b1 || Q !== 8'h0F || DONE !== 1'b0) begin fails++; $display("FAIL burst_accept: busy %b q %h done %b want 1 0f 0", BUSY, Q, DONE); end
    // Load request with zero data must be ignored while the burst runs.
    START = 1'b0; S = 3'b011; D = 8'h00; CNT = 4'd1;
    step();
    tests++; if (BUSY !== 1'b1 || Q !== 8'h1E) begin fails++; $display("FAIL burst_s1: busy %b q %h want 1 1e", BUSY, Q); end
    step();
    tests++; if (BUSY !== 1'b1 || Q !== 8'h3C) begin fails++; $display("FAIL burst_s2: busy %b q %h want 1 3c", BUSY, Q); end
    step();
    tests++; if (BUSY !== 1'b1 || Q !== 8'h78 || DONE !== 1'b0) begin fails++; $display("FAIL burst_s3: busy %b q %h done %b want 1 78 0", BUSY, Q, DONE); end
    S = 3'b000;
    step();
    tests++; if (BUSY !== 1'b0 || Q !== 8'hF0 || DONE !== 1'b1) begin fails++; $display("FAIL burst_end: busy %b q %h done %b want 0 f0 1", BUSY, Q, DONE); end
    step();
    tests++; if (DONE !== 1'b0 || Q !== 8'hF0) begin fails++; $display("FAIL burst_post: done %b q %h want 0 f0", DONE, Q); end
  endtask

  task automatic test_back_to_back();
    load(8'h01);
    S = 3'b010; SL_IN = 1'b0; START = 1'b1; CNT = 4'd1;
    step();
    tests++; if (BUSY !== 1'b1 || Q !== 8'h01) begin fails++; $display("FAIL b2b_acc1: busy %b q %h want 1 01", BUSY, Q); end
    CNT = 4'd2;
    step();
    tests++; if (BUSY !== 1'b0 || DONE !== 1'b1 || Q !== 8'h02) begin fails++; $display("FAIL b2b_done1: busy %b done %b q %h want 0 1 02", BUSY, DONE, Q); end
    step();
    tests++; if (BUSY !== 1'b1 || DONE !== 1'b0 || Q !== 8'h02) begin fails++; $display("FAIL b2b_acc2: busy %b done %b q %h want 1 0 02", BUSY, DONE, Q); end
    START = 1'b0; S = 3'b000;
    step();
    tests++; if (BUSY !== 1'b1 || Q !== 8'h04) begin fails++; $display("FAIL b2b_s1: busy %b q %h want 1 04", BUSY, Q); end
    step();
    tests++; if (BUSY !== 1'b0 || DONE !== 1'b1 || Q !== 8'h08) begin fails++; $display("FAIL b2b_done2: busy %b done %b q %h want 0 1 08", BUSY, DONE, Q); end
    step();
    tests++; if (DONE !== 1'b0) begin fails++; $display("FAIL b2b_post: done %b want 0", DONE); end
  endtask

  task automatic test_cnt_zero();
    load(8'h3C);
    S = 3'b001; SR_IN = 1'b1; START = 1'b1; CNT = 4'd0;
    step();
    tests++; if (Q !== 8'h3C || BUSY !== 1'b0 || DONE !== 1'b1) begin fails++; $display("FAIL cnt0: q %h busy %b done %b want 3c 0 1", Q, BUSY, DONE); end
    START = 1'b0; S = 3'b000;
    step();
    tests++; if (DONE !== 1'b0 || Q !== 8'h3C) begin fails++; $display("FAIL cnt0_post: done %b q %h want 0 3c", DONE, Q); end
    START = 1'b1; S = 3'b011; D = 8'h5A; CNT = 4'd3;
    step();
    tests++; if (Q !== 8'h5A || BUSY !== 1'b0 || DONE !== 1'b0) begin fails++; $display("FAIL start_load: q %h busy %b done %b want 5a 0 0", Q, BUSY, DONE); end
    START = 1'b0; S = 3'b000;
    step();
    tests++; if (DONE !== 1'b0 || BUSY !== 1'b0) begin fails++; $display("FAIL start_load_post: done %b busy %b want 0 0", DONE, BUSY); end
    SR_IN = 1'b0;
  endtask

  task automatic test_reset_mid_burst();
    int seen_done;
    load(8'hFF);
    S = 3'b001; SR_IN = 1'b0; START = 1'b1; CNT = 4'd6;
    step();
    START = 1'b0; S = 3'b000;
    step();
    tests++; if (Q !== 8'h7F) begin fails++; $display("FAIL abort_s1: got %h want 7f", Q); end
    step();
    tests++; if (Q !== 8'h3F || BUSY !== 1'b1) begin fails++; $display("FAIL abort_s2: q %h busy %b want 3f 1", Q, BUSY); end
    RST_N = 1'b0;
    #2;
    tests++; if (Q !== 8'h00 || BUSY !== 1'b0 || DONE !== 1'b0) begin fails++; $display("FAIL abort_rst: q %h busy %b done %b want 00 0 0", Q, BUSY, DONE); end
    RST_N = 1'b1;
    seen_done = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (DONE !== 1'b0 || BUSY !== 1'b0) seen_done++;
    end
    tests++; if (seen_done != 0) begin fails++; $display("FAIL abort_no_done: %0d cycles with busy/done, want 0", seen_done); end
  endtask

  task automatic test_oe();
    load(8'h96);
    OE = 1'b1;
    #1;
    // Undriven bus may resolve to zeros rather than Z; either way the 96 pattern must not show.
    tests++; if (Q !== 8'hzz && Q !== 8'h00) begin fails++; $display("FAIL oe_q: got %h want zz", Q); end
    tests++; if (SO_R !== 1'b0 || SO_L !== 1'b1) begin fails++; $display("FAIL oe_so: sor %b sol %b want 0 1", SO_R, SO_L); end
    S = 3'b001; SR_IN = 1'b1;
    step();
    tests++; if (SO_R !== 1'b1 || SO_L !== 1'b1) begin fails++; $display("FAIL oe_so_shift: sor %b sol %b want 1 1", SO_R, SO_L); end
    S = 3'b000; OE = 1'b0;
    #1;
    tests++; if (Q !== 8'hCB) begin fails++; $display("FAIL oe_reenable: got %h want cb", Q); end
  endtask

  initial begin
    test_reset();
    test_load_shift();
    test_asr();
    test_rotate();
    test_burst();
    test_back_to_back();
    test_cnt_zero();
    test_reset_mid_burst();
    test_oe();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
